// File: rtl/msf_pkg.sv
// Shared constants and helpers for the MSF receiver front end.
package msf_pkg;

  localparam int unsigned CLK_FREQ_DEF   = 12500;
  localparam int unsigned FILTER_LEN_DEF = 16;
  localparam int unsigned MIN_SEC_MS_DEF = 900;
  localparam int unsigned MAX_SEC_MS_DEF = 1100;
  localparam int unsigned LOSS_MS_DEF    = 2000;

  // Registered output bundle of the conditioner.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic signal_ok;
  } cond_out_t;

  // Converts a millisecond window to clock cycles; 64-bit product avoids overflow.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                               input int unsigned ms);
    longint unsigned prod;
    prod = 64'(clk_freq) * 64'(ms);
    return 32'(prod / 64'd1000);
  endfunction

endpackage

// File: rtl/msf_input_conditioner_if.sv
// Receiver-side signal bundle between the raw MSF pin and the bit sampler.
interface msf_input_conditioner_if;

  logic data_i;
  logic invert_i;
  logic data_o;
  logic rise_o;
  logic fall_o;
  logic signal_ok_o;

  modport master (
    output data_i,
    output invert_i,
    input  data_o,
    input  rise_o,
    input  fall_o,
    input  signal_ok_o
  );

  modport slave (
    input  data_i,
    input  invert_i,
    output data_o,
    output rise_o,
    output fall_o,
    output signal_ok_o
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; resets to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/msf_input_conditioner.sv
// MSF input conditioner: synchronise, glitch-filter with a hysteretic integrator,
// emit edge pulses and a second-interval health flag.
module msf_input_conditioner
  import msf_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF,
  parameter int unsigned MIN_SEC_MS = MIN_SEC_MS_DEF,
  parameter int unsigned MAX_SEC_MS = MAX_SEC_MS_DEF,
  parameter int unsigned LOSS_MS    = LOSS_MS_DEF
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  msf_input_conditioner_if.slave  bus
);

  localparam int unsigned CNT_W    = $clog2(FILTER_LEN);
  localparam int unsigned MIN_CYC  = ms_to_cycles(CLK_FREQ, MIN_SEC_MS);
  localparam int unsigned MAX_CYC  = ms_to_cycles(CLK_FREQ, MAX_SEC_MS);
  localparam int unsigned LOSS_CYC = ms_to_cycles(CLK_FREQ, LOSS_MS);
  localparam int unsigned TMR_W    = $clog2(LOSS_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(FILTER_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_SAT = TMR_W'(LOSS_CYC);
  localparam logic [TMR_W-1:0] TMR_MIN = TMR_W'(MIN_CYC);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MAX_CYC);

  logic             raw_c;
  logic             s2;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;
  cond_out_t        out_q;
  cond_out_t        out_d;

  // Polarity is applied ahead of the synchroniser so an invert change behaves like any input edge.
  assign raw_c = bus.data_i ^ bus.invert_i;

  sync_2ff u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (raw_c),
    .q_o    (s2)
  );

  // Saturating up/down integrator; data_o only moves when a rail is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (s2 && (cnt_q != CNT_TOP)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!s2 && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Output level, edge pulses, interval timer and health flag.
  always_comb begin
    out_d      = out_q;
    out_d.rise = 1'b0;
    out_d.fall = 1'b0;
    tmr_d      = tmr_q;

    if ((cnt_d == CNT_TOP) && !out_q.level) begin
      out_d.level = 1'b1;
      out_d.rise  = 1'b1;
    end else if ((cnt_d == '0) && out_q.level) begin
      out_d.level = 1'b0;
      out_d.fall  = 1'b1;
    end

    // Timer restarts the cycle after a rise pulse, otherwise counts up to the loss limit.
    if (out_q.rise) begin
      tmr_d = '0;
    end else if (tmr_q != TMR_SAT) begin
      tmr_d = tmr_q + TMR_W'(1);
    end

    // A rise judges the interval just ended and takes precedence over loss.
    if (out_d.rise) begin
      out_d.signal_ok = (tmr_q >= TMR_MIN) && (tmr_q <= TMR_MAX);
    end else if (tmr_d == TMR_SAT) begin
      out_d.signal_ok = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tmr_q <= '0;
      out_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      out_q <= out_d;
    end
  end

  assign bus.data_o      = out_q.level;
  assign bus.rise_o      = out_q.rise;
  assign bus.fall_o      = out_q.fall;
  assign bus.signal_ok_o = out_q.signal_ok;

endmodule

// File: tb/tb_msf_input_conditioner.sv
// Scoreboard bench for msf_input_conditioner, run at a reduced clock so one second is 2500 cycles.
module tb_msf_input_conditioner;

  localparam int FL     = 16;
  localparam int CF     = 2500;
  localparam int SEC    = 2500;   // 1000 ms
  localparam int MIN_C  = 2250;   // 900 ms
  localparam int MAX_C  = 2750;   // 1100 ms
  localparam int LOSS_C = 5000;   // 2000 ms

  typedef enum int {EV_RISE, EV_FALL, EV_LOSS} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       cyc;
    bit       ok;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ev_t      exp_q[$];
  ev_t      mon_e;
  ev_kind_e obs[$];
  bit       mon_en = 1'b0;
  bit       ok_prev = 1'b0;
  int       ev_seen = 0;

  // Bench model of the filtered level, health flag and timer origin.
  bit model_level;
  bit model_ok;
  int tmr_base;

  msf_input_conditioner_if bus ();

  msf_input_conditioner #(
    .CLK_FREQ   (CF),
    .FILTER_LEN (FL),
    .MIN_SEC_MS (900),
    .MAX_SEC_MS (1100),
    .LOSS_MS    (2000)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
    $fatal(1);
  end

  // Consumer side of the scoreboard: every DUT event must match the head of the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      obs.delete();
      if ((bus.rise_o !== 1'b1) && (bus.signal_ok_o !== ok_prev)) begin
        if (bus.signal_ok_o === 1'b0) begin
          obs.push_back(EV_LOSS);
        end else begin
          checks++;
          errors++;
          $display("FAIL spurious_ok: signal_ok_o=%b without rise_o at cyc %0d, required %b",
                   bus.signal_ok_o, cyc, ok_prev);
        end
      end
      if (bus.rise_o === 1'b1) obs.push_back(EV_RISE);
      if (bus.fall_o === 1'b1) obs.push_back(EV_FALL);
      foreach (obs[i]) begin
        ev_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %s at cyc %0d, required no event", obs[i].name(), cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if ((mon_e.kind != obs[i]) || (mon_e.cyc != cyc)) begin
            errors++;
            $display("FAIL event_order: got %s at cyc %0d, required %s at cyc %0d",
                     obs[i].name(), cyc, mon_e.kind.name(), mon_e.cyc);
          end else if (obs[i] != EV_LOSS) begin
            checks++;
            if ((bus.data_o !== (obs[i] == EV_RISE)) || (bus.signal_ok_o !== mon_e.ok)) begin
              errors++;
              $display("FAIL edge_state: %s at cyc %0d data_o=%b ok=%b, required data_o=%b ok=%b",
                       obs[i].name(), cyc, bus.data_o, bus.signal_ok_o, (obs[i] == EV_RISE), mon_e.ok);
            end
          end
        end
      end
    end
    ok_prev = bus.signal_ok_o;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the pin and pushes the events the filtered level change must produce.
  task automatic set_pin(input bit d, input bit inv);
    bit  eff;
    int  ec;
    int  t;
    ev_t e;
    bus.data_i   = d;
    bus.invert_i = inv;
    eff = d ^ inv;
    if (eff != model_level) begin
      model_level = eff;
      ec = cyc + FL + 1;
      e.cyc = ec;
      if (eff) begin
        t = ec - tmr_base - 1;
        if (t > LOSS_C) t = LOSS_C;
        model_ok = (t >= MIN_C) && (t <= MAX_C);
        tmr_base = ec + 1;
        e.kind = EV_RISE;
      end else begin
        e.kind = EV_FALL;
      end
      e.ok = model_ok;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse(input int high, input int period);
    set_pin(1'b1, 1'b0);
    tick(high);
    set_pin(1'b0, 1'b0);
    tick(period - high);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  task automatic do_reset(input bit d, input bit inv);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    exp_q.delete();
    bus.data_i   = d;
    bus.invert_i = inv;
    tick(3);
    rst_n       = 1'b1;
    tmr_base    = cyc;
    model_level = 1'b0;
    model_ok    = 1'b0;
    ok_prev     = 1'b0;
    mon_en      = 1'b1;
    set_pin(d, inv);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.data_i = 1'b1;
    bus.invert_i = 1'b0;
    tick(4);
    checks++;
    if (bus.data_o !== 1'b0) begin errors++; $display("FAIL reset_data: data_o=%b required 0", bus.data_o); end
    checks++;
    if (bus.rise_o !== 1'b0) begin errors++; $display("FAIL reset_rise: rise_o=%b required 0", bus.rise_o); end
    checks++;
    if (bus.fall_o !== 1'b0) begin errors++; $display("FAIL reset_fall: fall_o=%b required 0", bus.fall_o); end
    checks++;
    if (bus.signal_ok_o !== 1'b0) begin errors++; $display("FAIL reset_ok: signal_ok_o=%b required 0", bus.signal_ok_o); end
  endtask

  task automatic test_power_up_rise();
    do_reset(1'b1, 1'b0);
    wait_drain(FL + 10);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL powerup_timeout: %0d events pending, required 0", exp_q.size()); end
    checks++;
    if (bus.data_o !== 1'b1) begin errors++; $display("FAIL powerup_level: data_o=%b required 1", bus.data_o); end
    tick(1);
    checks++;
    if (bus.rise_o !== 1'b0) begin errors++; $display("FAIL powerup_pulse_width: rise_o=%b required 0", bus.rise_o); end
  endtask

  task automatic test_glitch_reject();
    int seen0;
    seen0 = ev_seen;
    bus.data_i = 1'b0;
    tick(5);
    bus.data_i = 1'b1;
    tick(40);
    checks++;
    if (bus.data_o !== 1'b1) begin errors++; $display("FAIL glitch_level: data_o=%b required 1", bus.data_o); end
    checks++;
    if (ev_seen != seen0) begin errors++; $display("FAIL glitch_events: %0d events seen, required 0", ev_seen - seen0); end
  endtask

  task automatic test_invert();
    do_reset(1'b0, 1'b1);
    wait_drain(FL + 10);
    checks++;
    if (bus.data_o !== 1'b1) begin errors++; $display("FAIL invert_rise: data_o=%b required 1", bus.data_o); end
    set_pin(1'b0, 1'b0);
    wait_drain(FL + 10);
    checks++;
    if ((bus.data_o !== 1'b0) || (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL invert_fall: data_o=%b pending=%0d, required data_o=0 pending=0", bus.data_o, exp_q.size());
    end
  endtask

  task automatic test_second_pulses();
    do_reset(1'b0, 1'b0);
    pulse(250, SEC);
    pulse(250, SEC);
    checks++;
    if (bus.signal_ok_o !== 1'b1) begin errors++; $display("FAIL second_ok: signal_ok_o=%b required 1", bus.signal_ok_o); end
    pulse(1250, SEC);
    pulse(250, SEC);
    checks++;
    if ((bus.signal_ok_o !== 1'b1) || (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL marker_ok: signal_ok_o=%b pending=%0d, required ok=1 pending=0", bus.signal_ok_o, exp_q.size());
    end
  endtask

  task automatic test_interval_window();
    int periods[9];
    periods = '{2000, 2800, 2500, MIN_C + 2, MAX_C + 2, MAX_C + 3, MIN_C + 1, SEC, SEC};
    foreach (periods[i]) pulse(250, periods[i]);
    checks++;
    if ((bus.signal_ok_o !== 1'b1) || (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL window_final: signal_ok_o=%b pending=%0d, required ok=1 pending=0", bus.signal_ok_o, exp_q.size());
    end
  endtask

  task automatic test_loss_and_reset();
    ev_t e;
    int  target;
    int  seen0;
    // Health drops once the timer, restarted after the last rise pulse, reaches the loss limit.
    e.kind = EV_LOSS;
    e.cyc  = tmr_base + LOSS_C;
    e.ok   = 1'b0;
    exp_q.push_back(e);
    model_ok = 1'b0;
    target = e.cyc + 5;
    while (cyc < target) tick(1);
    checks++;
    if ((bus.signal_ok_o !== 1'b0) || (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL loss: signal_ok_o=%b pending=%0d, required ok=0 pending=0", bus.signal_ok_o, exp_q.size());
    end
    pulse(250, SEC);
    set_pin(1'b1, 1'b0);
    tick(FL + 1 + 50);
    checks++;
    if ((bus.data_o !== 1'b1) || (bus.signal_ok_o !== 1'b1)) begin
      errors++;
      $display("FAIL pre_reset: data_o=%b ok=%b, required data_o=1 ok=1", bus.data_o, bus.signal_ok_o);
    end
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({bus.data_o, bus.rise_o, bus.fall_o, bus.signal_ok_o} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: data/rise/fall/ok=%b%b%b%b required 0000",
               bus.data_o, bus.rise_o, bus.fall_o, bus.signal_ok_o);
    end
    bus.data_i = 1'b0;
    tick(2);
    rst_n       = 1'b1;
    tmr_base    = cyc;
    model_level = 1'b0;
    model_ok    = 1'b0;
    ok_prev     = 1'b0;
    mon_en      = 1'b1;
    seen0 = ev_seen;
    tick(40);
    checks++;
    if ((ev_seen != seen0) || (bus.data_o !== 1'b0)) begin
      errors++;
      $display("FAIL release_quiet: events=%0d data_o=%b, required events=0 data_o=0", ev_seen - seen0, bus.data_o);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.data_i   = 1'b0;
    bus.invert_i = 1'b0;
    model_level  = 1'b0;
    model_ok     = 1'b0;
    tmr_base     = 0;
    test_reset();
    test_power_up_rise();
    test_glitch_reject();
    test_invert();
    test_second_pulses();
    test_interval_window();
    test_loss_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
